// File: rtl/gf2_min_weight_solver_if.sv
// Request/result bundle for gf2_min_weight_solver: matrix request in, solution out.
// start is a 1-cycle request accepted only while the block is idle (busy=0); ready then holds the result until the next accepted start.
interface gf2_min_weight_solver_if #(
    parameter int MAX_ROWS = 4,
    parameter int MAX_COLS = 7
);
    localparam int ROWS_W = ($clog2(MAX_ROWS + 1) > 0) ? $clog2(MAX_ROWS + 1) : 1;
    localparam int COLS_W = ($clog2(MAX_COLS + 1) > 0) ? $clog2(MAX_COLS + 1) : 1;
    localparam int WGT_W  = ($clog2(MAX_COLS) > 0) ? $clog2(MAX_COLS) : 1;

    logic [ROWS_W-1:0]                rows;
    logic [COLS_W-1:0]                cols;
    logic                             start;
    logic [MAX_ROWS-1:0][MAX_COLS-1:0] RREF;
    logic                             busy;
    logic                             ready;
    logic                             consistent;
    logic [MAX_COLS-2:0]              solution;
    logic [WGT_W-1:0]                 min_weight;
    logic [2:0]                       fsm_state;

    modport master (
        output rows, cols, start, RREF,
        input  busy, ready, consistent, solution, min_weight, fsm_state
    );

    modport slave (
        input  rows, cols, start, RREF,
        output busy, ready, consistent, solution, min_weight, fsm_state
    );
endinterface

// File: rtl/gf2_min_weight_solver.sv
// Minimum-weight solver for a reduced-row-echelon GF(2) system: scans pivots one row
// per cycle, then walks every free-variable assignment one candidate per cycle.
module gf2_min_weight_solver #(
    parameter int MAX_ROWS = 4,
    parameter int MAX_COLS = 7
) (
    input logic                    clk,
    input logic                    rst_n,
    gf2_min_weight_solver_if.slave bus
);
    localparam int NVARS  = MAX_COLS - 1;
    localparam int WGT_W  = ($clog2(MAX_COLS) > 0) ? $clog2(MAX_COLS) : 1;
    localparam int RIDX_W = ($clog2(MAX_ROWS) > 0) ? $clog2(MAX_ROWS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_PREP, S_ENUM, S_DONE} state_t;
    state_t state, state_next;

    logic [NVARS-1:0]  row_vars [MAX_ROWS];
    logic [MAX_ROWS-1:0] row_rhs;
    logic [NVARS-1:0]  pivot_oh [MAX_ROWS];
    logic [NVARS-1:0]  var_mask, pivot_mask, free_mask, s, best_x;
    logic [WGT_W:0]    best_w;
    logic [RIDX_W-1:0] row_idx, row_last;
    logic              incons;
    logic              busy_q, ready_q, consistent_q;
    logic [NVARS-1:0]  solution_q;
    logic [WGT_W-1:0]  min_weight_q;

    logic [NVARS-1:0]  in_vars [MAX_ROWS];
    logic [MAX_ROWS-1:0] in_rhs;
    logic [NVARS-1:0]  in_var_mask;
    logic [RIDX_W-1:0] in_row_last;
    logic [NVARS-1:0]  cur_vars, cur_oh, cand, s_next;
    logic [WGT_W:0]    cand_w;

    function automatic logic [WGT_W:0] popcount(input logic [NVARS-1:0] v);
        popcount = '0;
        for (int i = 0; i < NVARS; i++) popcount = popcount + {{WGT_W{1'b0}}, v[i]};
    endfunction

    // Masking happens at capture so the scan and walk only ever see active rows/columns.
    always_comb begin
        in_var_mask = '0;
        in_rhs      = '0;
        in_row_last = '0;
        for (int c = 0; c < NVARS; c++)
            if (c + 1 < int'(bus.cols)) in_var_mask[c] = 1'b1;
        for (int r = 0; r < MAX_ROWS; r++) begin
            in_vars[r] = '0;
            if (r < int'(bus.rows)) begin
                in_vars[r] = bus.RREF[r][NVARS-1:0] & in_var_mask;
                for (int c = 0; c < MAX_COLS; c++)
                    if (c + 1 == int'(bus.cols)) in_rhs[r] = bus.RREF[r][c];
            end
            if (r > 0 && r < int'(bus.rows)) in_row_last = RIDX_W'(r);
        end
    end

    always_comb begin
        cur_vars = row_vars[row_idx];
        cur_oh   = cur_vars & (~cur_vars + NVARS'(1));
        cand     = s;
        for (int r = 0; r < MAX_ROWS; r++)
            if ((^(row_vars[r] & s)) ^ row_rhs[r]) cand = cand | pivot_oh[r];
        cand_w   = popcount(cand);
        s_next   = (s - free_mask) & free_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // PREP settles free_mask from the completed pivot set before the walk starts.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_SCAN;
            S_SCAN:  if (row_idx == row_last) state_next = S_PREP;
            S_PREP:  state_next = incons ? S_DONE : S_ENUM;
            S_ENUM:  if (s_next == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < MAX_ROWS; r++) begin
                row_vars[r] <= '0;
                pivot_oh[r] <= '0;
            end
            row_rhs      <= '0;
            var_mask     <= '0;
            pivot_mask   <= '0;
            free_mask    <= '0;
            s            <= '0;
            best_x       <= '0;
            best_w       <= '0;
            row_idx      <= '0;
            row_last     <= '0;
            incons       <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            consistent_q <= 1'b0;
            solution_q   <= '0;
            min_weight_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    row_vars     <= in_vars;
                    row_rhs      <= in_rhs;
                    var_mask     <= in_var_mask;
                    row_last     <= in_row_last;
                    for (int r = 0; r < MAX_ROWS; r++) pivot_oh[r] <= '0;
                    row_idx      <= '0;
                    pivot_mask   <= '0;
                    incons       <= 1'b0;
                    busy_q       <= 1'b1;
                    ready_q      <= 1'b0;
                    consistent_q <= 1'b0;
                    solution_q   <= '0;
                    min_weight_q <= '0;
                end
                S_SCAN: begin
                    if (cur_vars != '0) begin
                        pivot_mask        <= pivot_mask | cur_oh;
                        pivot_oh[row_idx] <= cur_oh;
                    end else if (row_rhs[row_idx]) begin
                        incons <= 1'b1;
                    end
                    row_idx <= row_idx + RIDX_W'(1);
                end
                S_PREP: begin
                    free_mask <= ~pivot_mask & var_mask;
                    s         <= '0;
                    best_w    <= '1;
                    best_x    <= '0;
                end
                S_ENUM: begin
                    // Strictly-less keeps the earliest candidate on weight ties.
                    if (cand_w < best_w) begin
                        best_w <= cand_w;
                        best_x <= cand;
                    end
                    s <= s_next;
                end
                S_DONE: begin
                    busy_q       <= 1'b0;
                    ready_q      <= 1'b1;
                    consistent_q <= ~incons;
                    solution_q   <= incons ? '0 : best_x;
                    min_weight_q <= incons ? '0 : best_w[WGT_W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.ready      = ready_q;
    assign bus.consistent = consistent_q;
    assign bus.solution   = solution_q;
    assign bus.min_weight = min_weight_q;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_gf2_min_weight_solver.sv
// Bench for gf2_min_weight_solver: fixed scenarios plus randomized matrices checked
// against a brute-force equation-solving model.
module tb_gf2_min_weight_solver;
    localparam int MAX_ROWS = 4;
    localparam int MAX_COLS = 7;
    localparam int NV = MAX_COLS - 1;
    localparam int W = 8 + 1 + NV + 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    gf2_min_weight_solver_if #(.MAX_ROWS(MAX_ROWS), .MAX_COLS(MAX_COLS)) bus ();

    gf2_min_weight_solver #(.MAX_ROWS(MAX_ROWS), .MAX_COLS(MAX_COLS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- driver tasks ----------------
    task automatic drive_start(input int nr, input int nc, input logic [3:0][6:0] m);
        @(negedge clk);
        bus.rows  = 3'(nr);
        bus.cols  = 3'(nc);
        bus.RREF  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.ready) return;
        end
        cyc = -1;
    endtask

    // ---------------- reference model ----------------
    // Brute force over every assignment; ties go to the smallest free-variable part.
    function automatic void model_solve(input int nr, input int nc, input logic [3:0][6:0] m,
                                        output logic cons, output logic [NV-1:0] sol,
                                        output int wt, output int lat);
        int nv, best_w, best_key, pc, key, rr;
        logic [NV-1:0] vmask, pivots, free, vars, xv;
        logic rhs, ok;
        nv = (nc > 0) ? nc - 1 : 0;
        vmask = '0;
        for (int c = 0; c < nv; c++) vmask[c] = 1'b1;
        pivots = '0;
        for (int r = 0; r < nr; r++) begin
            vars = m[r][NV-1:0] & vmask;
            for (int c = 0; c < nv; c++)
                if (vars[c]) begin
                    pivots[c] = 1'b1;
                    break;
                end
        end
        free = vmask & ~pivots;
        cons = 1'b0; sol = '0; wt = 0; best_w = 99; best_key = 0;
        for (int x = 0; x < (1 << nv); x++) begin
            xv = NV'(x);
            ok = 1'b1;
            for (int r = 0; r < nr; r++) begin
                vars = m[r][NV-1:0] & vmask;
                rhs = 1'b0;
                if (nc > 0) rhs = m[r][nc-1];
                if (($countones(vars & xv) % 2) != int'(rhs)) ok = 1'b0;
            end
            if (ok) begin
                pc  = $countones(xv);
                key = int'(xv & free);
                if (!cons || pc < best_w || (pc == best_w && key < best_key)) begin
                    best_w = pc; best_key = key; sol = xv;
                end
                cons = 1'b1;
            end
        end
        if (cons) wt = best_w;
        rr = (nr > 0) ? nr : 1;
        lat = cons ? rr + (1 << $countones(free)) + 2 : rr + 2;
    endfunction

    // Well-formed RREF inside the active window, random garbage outside it.
    task automatic gen_case(output int nr, output int nc, output logic [3:0][6:0] m);
        int nv, k;
        int piv [4];
        logic [6:0] row_val, act;
        logic [NV-1:0] pmask;
        nr = $urandom_range(0, MAX_ROWS);
        nc = $urandom_range(0, MAX_COLS);
        nv = (nc > 0) ? nc - 1 : 0;
        act = 7'((1 << nc) - 1);
        k = 0;
        pmask = '0;
        for (int i = 0; i < 4; i++) piv[i] = 0;
        for (int c = 0; c < nv; c++)
            if (k < nr && $urandom_range(0, 2) != 0) begin
                piv[k] = c; pmask[c] = 1'b1; k++;
            end
        for (int r = 0; r < MAX_ROWS; r++) begin
            m[r] = 7'($urandom);
            if (r < nr) begin
                row_val = '0;
                if (r < k) begin
                    row_val[piv[r]] = 1'b1;
                    for (int c = piv[r] + 1; c < nv; c++)
                        if (!pmask[c]) row_val[c] = 1'($urandom);
                    if (nc > 0) row_val[nc-1] = 1'($urandom);
                end else if (nc > 0) begin
                    row_val[nc-1] = ($urandom_range(0, 5) == 0);
                end
                m[r] = (m[r] & ~act) | row_val;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.rows = '0; bus.cols = '0; bus.RREF = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy, bus.ready, bus.consistent, bus.solution, bus.min_weight} !== '0) begin
            $display("FAIL reset_outputs: got %b want 0",
                     {bus.busy, bus.ready, bus.consistent, bus.solution, bus.min_weight});
            n_err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy, bus.ready} !== 2'b00) begin
            $display("FAIL idle_after_reset: busy/ready got %b want 00", {bus.busy, bus.ready});
            n_err++;
        end
    endtask

    task automatic run_fixed(input string name, input int nr, input int nc,
                             input logic [3:0][6:0] m, input logic [NV+3:0] exp_res,
                             input int exp_lat);
        int cyc;
        drive_start(nr, nc, m);
        wait_ready(200, cyc);
        n_vec++;
        if (cyc !== exp_lat) begin
            $display("FAIL %s_latency: got %0d want %0d", name, cyc, exp_lat);
            n_err++;
        end
        n_vec++;
        if ({bus.consistent, bus.solution, bus.min_weight} !== exp_res) begin
            $display("FAIL %s_result: got %b want %b", name,
                     {bus.consistent, bus.solution, bus.min_weight}, exp_res);
            n_err++;
        end
    endtask

    task automatic test_fixed_vectors();
        logic [3:0][6:0] m;
        m = '0; m[0] = 7'b1011101; m[1] = 7'b0000110; m[2] = 7'b1111111;
        run_fixed("two_row", 2, 4, m, {1'b1, 6'b000001, 3'd1}, 6);
        m = '0; m[0] = 7'b0000100;
        run_fixed("inconsistent", 1, 3, m, {1'b0, 6'b000000, 3'd0}, 3);
        m = '0; m[0] = 7'b0000111;
        run_fixed("tie", 1, 3, m, {1'b1, 6'b000001, 3'd1}, 5);
        m = '0; m[0] = 7'b0000001;
        run_fixed("cols_one", 1, 1, m, {1'b0, 6'b000000, 3'd0}, 3);
    endtask

    task automatic test_all_free();
        logic [3:0][6:0] m;
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) m[i] = 7'($urandom);
        drive_start(0, 7, m);
        for (int i = 1; i < 67; i++) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b1 || bus.ready !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            $display("FAIL all_free_busy_window: %0d bad cycles, want 0", bad);
            n_err++;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.ready, bus.busy, bus.consistent, bus.solution, bus.min_weight} !==
            {1'b1, 1'b0, 1'b1, 6'b0, 3'd0}) begin
            $display("FAIL all_free_result: got %b want %b",
                     {bus.ready, bus.busy, bus.consistent, bus.solution, bus.min_weight},
                     {1'b1, 1'b0, 1'b1, 6'b0, 3'd0});
            n_err++;
        end
    endtask

    task automatic test_ignored_start();
        logic [3:0][6:0] a, b;
        int cyc;
        a = '0; a[0] = 7'b0001101; a[1] = 7'b0000110;
        b = '0; b[0] = 7'b1111111; b[1] = 7'b1111111;
        drive_start(2, 4, a);
        bus.rows = 3'd1; bus.cols = 3'd7; bus.RREF = b; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_ready(200, cyc);
        n_vec++;
        if (cyc < 0 || cyc + 1 !== 6) begin
            $display("FAIL ignored_start_latency: got %0d want 6", cyc + 1);
            n_err++;
        end
        n_vec++;
        if ({bus.consistent, bus.solution, bus.min_weight} !== {1'b1, 6'b000001, 3'd1}) begin
            $display("FAIL ignored_start_result: got %b want %b",
                     {bus.consistent, bus.solution, bus.min_weight}, {1'b1, 6'b000001, 3'd1});
            n_err++;
        end
    endtask

    task automatic test_reset_mid_enum();
        logic [3:0][6:0] m;
        m[0] = 7'b1010001; m[1] = 7'b0100010; m[2] = 7'b1000100; m[3] = 7'b1111000;
        drive_start(4, 7, m);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.busy, bus.ready, bus.consistent, bus.solution, bus.min_weight} !== '0) begin
            $display("FAIL mid_enum_reset: got %b want 0",
                     {bus.busy, bus.ready, bus.consistent, bus.solution, bus.min_weight});
            n_err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy, bus.ready} !== 2'b00) begin
            $display("FAIL mid_enum_no_result: busy/ready got %b want 00", {bus.busy, bus.ready});
            n_err++;
        end
        run_fixed("four_row", 4, 7, m, {1'b1, 6'b010100, 3'd2}, 10);
    endtask

    task automatic test_back_to_back();
        logic [3:0][6:0] a, b;
        int cyc;
        a = '0; a[0] = 7'b0001101; a[1] = 7'b0000110;
        b = '0; b[0] = 7'b0000111;
        run_fixed("b2b_first", 2, 4, a, {1'b1, 6'b000001, 3'd1}, 6);
        drive_start(1, 3, b);
        n_vec++;
        if ({bus.ready, bus.busy} !== 2'b01) begin
            $display("FAIL b2b_ready_drop: ready/busy got %b want 01", {bus.ready, bus.busy});
            n_err++;
        end
        wait_ready(200, cyc);
        n_vec++;
        if (cyc !== 5) begin
            $display("FAIL b2b_latency: got %0d want 5", cyc);
            n_err++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.ready, bus.consistent, bus.solution, bus.min_weight} !== {1'b1, 1'b1, 6'b000001, 3'd1}) begin
            $display("FAIL b2b_held_result: got %b want %b",
                     {bus.ready, bus.consistent, bus.solution, bus.min_weight},
                     {1'b1, 1'b1, 6'b000001, 3'd1});
            n_err++;
        end
    endtask

    task automatic test_random();
        logic [3:0][6:0] m;
        logic cons;
        logic [NV-1:0] sol;
        logic [W-1:0] e;
        int nr, nc, wt, lat, cyc;
        for (int t = 0; t < 40; t++) begin
            gen_case(nr, nc, m);
            model_solve(nr, nc, m, cons, sol, wt, lat);
            exp_q.push_back({8'(lat), cons, sol, 3'(wt)});
            drive_start(nr, nc, m);
            wait_ready(200, cyc);
            e = exp_q.pop_front();
            n_vec++;
            if (cyc < 0 || 8'(cyc) !== e[W-1 -: 8]) begin
                $display("FAIL rand%0d_latency: got %0d want %0d (rows=%0d cols=%0d)",
                         t, cyc, e[W-1 -: 8], nr, nc);
                n_err++;
            end
            n_vec++;
            if ({bus.consistent, bus.solution, bus.min_weight} !== e[NV+3:0]) begin
                $display("FAIL rand%0d_result: got %b want %b (rows=%0d cols=%0d m=%h)",
                         t, {bus.consistent, bus.solution, bus.min_weight}, e[NV+3:0], nr, nc, m);
                n_err++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed_vectors();
        test_all_free();
        test_ignored_start();
        test_reset_mid_enum();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
